// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared widths, entry/packet types and opcode constants for the issue queue
package iq_pkg;

    localparam int IQ_PREG_W = 6;
    localparam int IQ_DATA_W = 32;
    localparam int IQ_ROB_W  = 6;
    localparam int IQ_FU_W   = 2;

    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef struct packed {
        logic                 valid;
        logic [IQ_FU_W-1:0]   fu;
        logic [IQ_PREG_W-1:0] rd;
        logic [IQ_PREG_W-1:0] rs1;
        logic [IQ_DATA_W-1:0] rs1_val;
        logic                 rs1_rdy;
        logic [IQ_PREG_W-1:0] rs2;
        logic [IQ_DATA_W-1:0] rs2_val;
        logic                 rs2_rdy;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [6:0]           opcode;
        logic [IQ_DATA_W-1:0] imm;
        logic [IQ_ROB_W-1:0]  rob;
    } iq_entry_t;

    // Field order puts rob in the MSBs and rs1_val in the LSBs of each issue lane
    typedef struct packed {
        logic [IQ_ROB_W-1:0]  rob;
        logic [IQ_PREG_W-1:0] rd;
        logic [6:0]           opcode;
        logic [6:0]           funct7;
        logic [2:0]           funct3;
        logic [IQ_DATA_W-1:0] imm;
        logic [IQ_DATA_W-1:0] rs2_val;
        logic [IQ_DATA_W-1:0] rs1_val;
    } iq_issue_pkt_t;

    localparam int PKT_W = $bits(iq_issue_pkt_t);

endpackage

// File: rtl/iq_age_select.sv
// rtl/iq_age_select.sv - one-hot oldest-candidate pick from an age matrix
module iq_age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]       cand,
    input  logic [DEPTH*DEPTH-1:0] age_flat,
    output logic [DEPTH-1:0]       grant
);

    // Row i of the matrix marks entries older than i; i wins when no older entry is a candidate
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = cand[i] & ~|(cand & age_flat[i*DEPTH +: DEPTH]);
        end
    end

endmodule

// File: rtl/issue_queue_multi.sv
// rtl/issue_queue_multi.sv - unified age-ordered issue queue with wakeup capture and per-FU select
module issue_queue_multi
    import iq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int NUM_FU     = 3,
    parameter int NUM_WAKEUP = 4,
    parameter int PREG_W     = IQ_PREG_W,
    parameter int DATA_W     = IQ_DATA_W,
    parameter int ROB_W      = IQ_ROB_W,
    localparam int FU_W      = $clog2(NUM_FU),
    localparam int OCC_W     = $clog2(DEPTH + 1),
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [FU_W-1:0]              disp_fu,
    input  logic [PREG_W-1:0]            disp_rd,
    input  logic [PREG_W-1:0]            disp_rs1,
    input  logic [PREG_W-1:0]            disp_rs2,
    input  logic                         disp_rs1_rdy,
    input  logic                         disp_rs2_rdy,
    input  logic [DATA_W-1:0]            disp_rs1_val,
    input  logic [DATA_W-1:0]            disp_rs2_val,
    input  logic [2:0]                   disp_funct3,
    input  logic [6:0]                   disp_funct7,
    input  logic [6:0]                   disp_opcode,
    input  logic [DATA_W-1:0]            disp_imm,
    input  logic [ROB_W-1:0]             disp_rob,
    input  logic [NUM_WAKEUP-1:0]        wk_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wk_tag,
    input  logic [NUM_WAKEUP*DATA_W-1:0] wk_val,
    output logic [NUM_FU-1:0]            iss_valid,
    input  logic [NUM_FU-1:0]            iss_ready,
    output logic [NUM_FU*PKT_W-1:0]      iss_pkt,
    output logic [OCC_W-1:0]             occupancy
);

    iq_entry_t              q [DEPTH];
    logic [DEPTH-1:0]       age [DEPTH];
    logic [DEPTH*DEPTH-1:0] age_flat;
    logic [DEPTH-1:0]       valid_vec;
    logic [DEPTH-1:0]       cand  [NUM_FU];
    logic [DEPTH-1:0]       grant [NUM_FU];
    logic [DEPTH-1:0]       issued;
    logic [OCC_W-1:0]       issue_cnt;
    logic [DEPTH-1:0]       rs1_hit, rs2_hit;
    logic [DATA_W-1:0]      rs1_wv [DEPTH];
    logic [DATA_W-1:0]      rs2_wv [DEPTH];
    logic [IDX_W-1:0]       alloc_idx;
    logic                   disp_fire;
    logic                   d1_hit, d2_hit;
    logic [DATA_W-1:0]      d1_wv, d2_wv;
    iq_entry_t              new_entry;

    // Lowest-numbered bus wins when several buses carry the same tag
    function automatic logic wk_lookup(input logic [PREG_W-1:0] tag,
                                       input logic [NUM_WAKEUP-1:0] v,
                                       input logic [NUM_WAKEUP*PREG_W-1:0] tags,
                                       input logic [NUM_WAKEUP*DATA_W-1:0] vals,
                                       output logic [DATA_W-1:0] val);
        logic hit;
        hit = 1'b0;
        val = '0;
        for (int k = NUM_WAKEUP - 1; k >= 0; k--) begin
            if (v[k] && tags[k*PREG_W +: PREG_W] == tag) begin
                hit = 1'b1;
                val = vals[k*DATA_W +: DATA_W];
            end
        end
        return hit;
    endfunction

    assign disp_ready = (occupancy < OCC_W'(DEPTH));
    assign disp_fire  = disp_valid & disp_ready;

    // Flatten state views and find the lowest free slot
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            valid_vec[i] = q[i].valid;
            age_flat[i*DEPTH +: DEPTH] = age[i];
            if (!q[i].valid) alloc_idx = IDX_W'(i);
        end
    end

    // Wakeup matches for resident entries and the incoming dispatch
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit[i] = wk_lookup(q[i].rs1, wk_valid, wk_tag, wk_val, rs1_wv[i]);
            rs2_hit[i] = wk_lookup(q[i].rs2, wk_valid, wk_tag, wk_val, rs2_wv[i]);
        end
        d1_hit = wk_lookup(disp_rs1, wk_valid, wk_tag, wk_val, d1_wv);
        d2_hit = wk_lookup(disp_rs2, wk_valid, wk_tag, wk_val, d2_wv);
    end

    // Build the new entry, folding in a same-cycle wakeup for operands not yet ready
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.fu      = IQ_FU_W'(disp_fu);
        new_entry.rd      = disp_rd;
        new_entry.rs1     = disp_rs1;
        new_entry.rs2     = disp_rs2;
        new_entry.rs1_rdy = disp_rs1_rdy | d1_hit;
        new_entry.rs2_rdy = disp_rs2_rdy | d2_hit;
        new_entry.rs1_val = disp_rs1_rdy ? disp_rs1_val : d1_wv;
        new_entry.rs2_val = disp_rs2_rdy ? disp_rs2_val : d2_wv;
        new_entry.funct3  = disp_funct3;
        new_entry.funct7  = disp_funct7;
        new_entry.opcode  = disp_opcode;
        new_entry.imm     = disp_imm;
        new_entry.rob     = disp_rob;
    end

    // Per-FU candidate vectors: valid, both operands ready, targeted at that FU
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                cand[f][i] = q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy && (q[i].fu == IQ_FU_W'(f));
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        iq_age_select #(.DEPTH(DEPTH)) u_sel (
            .cand     (cand[f]),
            .age_flat (age_flat),
            .grant    (grant[f])
        );
    end

    // Drive issue lanes from the one-hot grants; idle lanes stay zero
    always_comb begin
        iq_issue_pkt_t pkt;
        iss_valid = '0;
        iss_pkt   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            pkt = '0;
            iss_valid[f] = |grant[f];
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[f][i]) begin
                    pkt = pkt | iq_issue_pkt_t'({q[i].rob, q[i].rd, q[i].opcode, q[i].funct7,
                                                 q[i].funct3, q[i].imm, q[i].rs2_val, q[i].rs1_val});
                end
            end
            iss_pkt[f*PKT_W +: PKT_W] = pkt;
        end
    end

    // Entries leaving this cycle and how many
    always_comb begin
        issued    = '0;
        issue_cnt = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (iss_ready[f]) issued = issued | grant[f];
            issue_cnt = issue_cnt + OCC_W'(iss_valid[f] & iss_ready[f]);
        end
    end

    // Queue state: flush beats everything, otherwise wakeup, issue and allocate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i]   <= '0;
                age[i] <= '0;
            end
            occupancy <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(disp_fire) - issue_cnt;
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid && !q[i].rs1_rdy && rs1_hit[i]) begin
                    q[i].rs1_rdy <= 1'b1;
                    q[i].rs1_val <= rs1_wv[i];
                end
                if (q[i].valid && !q[i].rs2_rdy && rs2_hit[i]) begin
                    q[i].rs2_rdy <= 1'b1;
                    q[i].rs2_val <= rs2_wv[i];
                end
                if (issued[i]) q[i].valid <= 1'b0;
                // A reused slot must not inherit "older than" marks from its previous occupant
                if (disp_fire) age[i][alloc_idx] <= 1'b0;
            end
            if (disp_fire) begin
                q[alloc_idx]   <= new_entry;
                age[alloc_idx] <= valid_vec;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_multi.sv
// tb/tb_issue_queue_multi.sv - scoreboard bench for issue_queue_multi
module tb_issue_queue_multi;
    import iq_pkg::*;

    localparam int DEPTH = 16, NUM_FU = 3, NUM_WAKEUP = 4;

    logic clk = 1'b0;
    logic reset_n, flush, disp_valid, disp_ready;
    logic [1:0] disp_fu;
    logic [5:0] disp_rd, disp_rs1, disp_rs2;
    logic disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0] disp_rs1_val, disp_rs2_val, disp_imm;
    logic [2:0] disp_funct3;
    logic [6:0] disp_funct7, disp_opcode;
    logic [5:0] disp_rob;
    logic [NUM_WAKEUP-1:0] wk_valid;
    logic [NUM_WAKEUP*6-1:0] wk_tag;
    logic [NUM_WAKEUP*32-1:0] wk_val;
    logic [NUM_FU-1:0] iss_valid, iss_ready;
    logic [NUM_FU*PKT_W-1:0] iss_pkt;
    logic [4:0] occupancy;

    int checks = 0;
    int fails = 0;
    iq_issue_pkt_t exp_q [NUM_FU][$];

    always #5 clk = ~clk;

    issue_queue_multi dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
        .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .disp_funct3(disp_funct3), .disp_funct7(disp_funct7), .disp_opcode(disp_opcode),
        .disp_imm(disp_imm), .disp_rob(disp_rob),
        .wk_valid(wk_valid), .wk_tag(wk_tag), .wk_val(wk_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pkt(iss_pkt),
        .occupancy(occupancy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic iq_issue_pkt_t mk(input logic [5:0] rob, input logic [5:0] rd,
                                         input logic [31:0] imm, input logic [31:0] v2,
                                         input logic [31:0] v1);
        iq_issue_pkt_t p;
        p.rob = rob; p.rd = rd; p.opcode = OP_ALU; p.funct7 = 7'h00;
        p.funct3 = rob[2:0]; p.imm = imm; p.rs2_val = v2; p.rs1_val = v1;
        return p;
    endfunction

    function automatic iq_issue_pkt_t lane(input int f);
        return iss_pkt[f*PKT_W +: PKT_W];
    endfunction

    // Scoreboard monitor: every accepted issue must match the next expected packet for that FU
    always @(negedge clk) begin
        if (reset_n && !flush) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (iss_valid[f] && iss_ready[f]) begin
                    if (exp_q[f].size() == 0) begin
                        check($sformatf("unexpected_issue_fu%0d", f), 128'(lane(f)), 128'h0);
                    end else begin
                        check($sformatf("issue_pkt_fu%0d", f), 128'(lane(f)), 128'(exp_q[f].pop_front()));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input int fu, input logic [5:0] rd,
                        input logic [5:0] rs1, input logic r1rdy, input logic [31:0] v1,
                        input logic [5:0] rs2, input logic r2rdy, input logic [31:0] v2,
                        input logic [5:0] rob, input logic [31:0] imm);
        disp_valid = 1'b1; disp_fu = 2'(fu); disp_rd = rd;
        disp_rs1 = rs1; disp_rs1_rdy = r1rdy; disp_rs1_val = v1;
        disp_rs2 = rs2; disp_rs2_rdy = r2rdy; disp_rs2_val = v2;
        disp_rob = rob; disp_imm = imm; disp_funct3 = rob[2:0];
        disp_funct7 = 7'h00; disp_opcode = OP_ALU;
    endtask

    task automatic set_wk(input int k, input logic [5:0] tag, input logic [31:0] val);
        wk_valid[k] = 1'b1;
        wk_tag[k*6 +: 6] = tag;
        wk_val[k*32 +: 32] = val;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_fu = '0;
        disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
        disp_rs1_val = '0; disp_rs2_val = '0; disp_imm = '0; disp_funct3 = '0;
        disp_funct7 = '0; disp_opcode = '0; disp_rob = '0;
        wk_valid = '0; wk_tag = '0; wk_val = '0; iss_ready = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset / idle state
        check("reset_occupancy", 128'(occupancy), 128'd0);
        check("reset_disp_ready", 128'(disp_ready), 128'd1);
        check("reset_iss_valid", 128'(iss_valid), 128'd0);
        check("reset_iss_pkt", 128'(iss_pkt), 128'd0);

        // Dispatch waiting on tag 5, then wakeup on bus 1
        disp(0, 6'd10, 6'd5, 1'b0, 32'h0, 6'd5, 1'b0, 32'h0, 6'd20, 32'h12345678);
        step();
        disp_valid = 1'b0;
        check("wait_occupancy", 128'(occupancy), 128'd1);
        check("wait_not_issued", 128'(iss_valid), 128'd0);
        set_wk(1, 6'd5, 32'hCAFEBABE);
        exp_q[0].push_back(mk(6'd20, 6'd10, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE));
        iss_ready[0] = 1'b1;
        step();
        wk_valid = '0;
        check("woken_iss_valid0", 128'(iss_valid), 128'b001);
        step();
        iss_ready[0] = 1'b0;
        check("woken_occupancy", 128'(occupancy), 128'd0);

        // Age order on FU1 with back-pressure
        disp(1, 6'd11, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22, 6'd1, 32'h1);
        step();
        disp(1, 6'd12, 6'd3, 1'b1, 32'h33, 6'd4, 1'b1, 32'h44, 6'd2, 32'h2);
        step();
        disp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_rob_a", 128'(lane(1).rob), 128'd1);
        end
        exp_q[1].push_back(mk(6'd1, 6'd11, 32'h1, 32'h22, 32'h11));
        exp_q[1].push_back(mk(6'd2, 6'd12, 32'h2, 32'h44, 32'h33));
        iss_ready[1] = 1'b1;
        step();
        check("next_rob_b", 128'(lane(1).rob), 128'd2);
        step();
        iss_ready[1] = 1'b0;
        check("age_occupancy", 128'(occupancy), 128'd0);

        // Fill to capacity on FU2; overflow dispatch must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            disp(2, 6'(i + 32), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i * 2), 6'(i), 32'(i + 100));
            step();
        end
        check("full_occupancy", 128'(occupancy), 128'd16);
        check("full_disp_ready", 128'(disp_ready), 128'd0);
        disp(2, 6'd63, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 6'd63, 32'hDEAD);
        step();
        disp_valid = 1'b0;
        check("overflow_dropped", 128'(occupancy), 128'd16);
        check("full_oldest_rob", 128'(lane(2).rob), 128'd0);
        exp_q[2].push_back(mk(6'd0, 6'd32, 32'd100, 32'd0, 32'd0));
        iss_ready[2] = 1'b1;
        step();
        iss_ready[2] = 1'b0;
        check("release_occupancy", 128'(occupancy), 128'd15);
        check("release_disp_ready", 128'(disp_ready), 128'd1);
        for (int i = 1; i < DEPTH; i++) begin
            exp_q[2].push_back(mk(6'(i), 6'(i + 32), 32'(i + 100), 32'(i * 2), 32'(i)));
        end
        iss_ready[2] = 1'b1;
        repeat (DEPTH - 1) step();
        iss_ready[2] = 1'b0;
        check("drain_occupancy", 128'(occupancy), 128'd0);

        // Dispatch/wakeup bypass on rs2
        disp(0, 6'd13, 6'd1, 1'b1, 32'h7, 6'd9, 1'b0, 32'h0, 6'd5, 32'h55);
        set_wk(0, 6'd9, 32'hFFFFFFFF);
        exp_q[0].push_back(mk(6'd5, 6'd13, 32'h55, 32'hFFFFFFFF, 32'h7));
        iss_ready[0] = 1'b1;
        step();
        disp_valid = 1'b0;
        wk_valid = '0;
        check("bypass_iss_valid", 128'(iss_valid), 128'b001);
        step();
        check("bypass_occupancy", 128'(occupancy), 128'd0);

        // Two buses match the same tag: lower bus supplies the value
        disp(0, 6'd14, 6'd12, 1'b0, 32'h0, 6'd1, 1'b1, 32'h9, 6'd6, 32'h66);
        step();
        disp_valid = 1'b0;
        set_wk(3, 6'd12, 32'hBBBBBBBB);
        set_wk(2, 6'd12, 32'hAAAAAAAA);
        exp_q[0].push_back(mk(6'd6, 6'd14, 32'h66, 32'h9, 32'hAAAAAAAA));
        step();
        wk_valid = '0;
        step();
        iss_ready[0] = 1'b0;
        check("multi_wk_occupancy", 128'(occupancy), 128'd0);

        // Flush with one ready entry per FU and all FUs accepting
        for (int f = 0; f < NUM_FU; f++) begin
            disp(f, 6'd20, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'(40 + f), 32'h0);
            step();
        end
        disp_valid = 1'b0;
        check("pre_flush_valid", 128'(iss_valid), 128'b111);
        flush = 1'b1;
        iss_ready = 3'b111;
        step();
        flush = 1'b0;
        iss_ready = '0;
        check("flush_occupancy", 128'(occupancy), 128'd0);
        check("flush_iss_valid", 128'(iss_valid), 128'd0);
        disp(0, 6'd21, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 32'h4, 6'd33, 32'h77);
        exp_q[0].push_back(mk(6'd33, 6'd21, 32'h77, 32'h4, 32'h3));
        step();
        disp_valid = 1'b0;
        check("post_flush_occupancy", 128'(occupancy), 128'd1);
        iss_ready[0] = 1'b1;
        step();
        iss_ready = '0;
        check("post_flush_drain", 128'(occupancy), 128'd0);

        for (int f = 0; f < NUM_FU; f++) begin
            check($sformatf("scoreboard_empty_fu%0d", f), 128'(exp_q[f].size()), 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
